// File: rtl/wait_sample_collector_if.sv
// Handshake bundle for wait_sample_collector: run control, sampled bus,
// FIFO head with valid/ready, occupancy, sticky overflow and busy status.
interface wait_sample_collector_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   logic                       start;
   logic signed [DATA_W-1:0]   in_data;
   logic                       out_ready;
   logic signed [DATA_W-1:0]   out_data;
   logic                       out_valid;
   logic [$clog2(DEPTH):0]     count;
   logic                       overflow;
   logic                       busy;

   modport slave (
      input  start, in_data, out_ready,
      output out_data, out_valid, count, overflow, busy
   );

   modport master (
      output start, in_data, out_ready,
      input  out_data, out_valid, count, overflow, busy
   );
endinterface

// File: rtl/wait_sample_collector.sv
// Samples in_data once per WAIT_CYCLES+1 window, buffers in a FWFT FIFO.
// Ports: clk, reset (async active-low), bus (slave). Macro: SAMPLE_ACCUM_EN.
module wait_sample_collector #(
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 4,
   parameter int DEPTH       = 4
) (
   input  logic clk,
   input  logic reset,
   wait_sample_collector_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CNW = AW + 1;
   localparam int CW  = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2
   } state_e;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     busy_q, busy_d;
   logic [AW-1:0]            wr_q, wr_d;
   logic [AW-1:0]            rd_q, rd_d;
   logic [CNW-1:0]           count_q, count_d;
   logic                     ovf_q, ovf_d;
   logic signed [DATA_W-1:0] mem_q [DEPTH];
   logic signed [DATA_W-1:0] mem_d [DEPTH];
   logic signed [DATA_W-1:0] sample;
   logic                     push, pop, full, accept;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cnt_d   = CW'(WAIT_CYCLES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (bus.start) begin
               cnt_d   = CW'(WAIT_CYCLES);
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

`ifdef SAMPLE_ACCUM_EN
   localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W:0]          sum;

   always_comb begin
      sum   = {acc_q[DATA_W-1], acc_q} + {bus.in_data[DATA_W-1], bus.in_data};
      acc_d = acc_q;
      if (state_q == S_WAIT) begin
         // Sign bits disagree: the add left the DATA_W range, clamp it.
         if (sum[DATA_W] != sum[DATA_W-1])
            acc_d = sum[DATA_W] ? SMIN : SMAX;
         else
            acc_d = sum[DATA_W-1:0];
      end
      // Entry to WAIT only happens from IDLE or CAPTURE.
      if (state_d == S_WAIT && state_q != S_WAIT) acc_d = '0;
      sample = acc_q;
   end
`else
   always_comb begin
      sample = bus.in_data;
   end
`endif

   always_comb begin
      push    = (state_q == S_CAPTURE);
      pop     = (count_q != '0) && bus.out_ready;
      full    = (count_q == CNW'(DEPTH));
      // A pop in the same cycle frees the slot the push needs.
      accept  = push && (!full || pop);
      mem_d   = mem_q;
      if (accept) mem_d[wr_q] = sample;
      wr_d    = wr_q + AW'(accept);
      rd_d    = rd_q + AW'(pop);
      count_d = count_q + CNW'(accept) - CNW'(pop);
      ovf_d   = ovf_q | (push & full & ~pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef SAMPLE_ACCUM_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         mem_q   <= mem_d;
`ifdef SAMPLE_ACCUM_EN
         acc_q   <= acc_d;
`endif
      end
   end

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = bus.out_valid ? mem_q[rd_q] : '0;
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
   assign bus.busy      = busy_q;
endmodule
